// File: rtl/store_merge_if.sv
// CPU store request/response plus word-RAM port of the sub-word store unit.
// slave is the store unit; master is the CPU MEM stage together with the RAM.
interface store_merge_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_merge.sv
// Sub-word store unit: SW writes directly (resp +2); SH/SB read-modify-write a word RAM (resp +4); errors resp +1.
// One request in flight; req_ready drops while busy and the CPU must hold its request.
module store_merge #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int ADDR_W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    store_merge_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_RWAIT = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    logic [2:0]        state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       merged_q;

    logic        accept;
    logic        req_err;
    logic [31:0] req_trunc;
    logic [4:0]  lane_sh;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic        mem_en;
    logic        mem_we;

    assign accept = bus.req_valid & bus.req_ready;

    always_comb begin
        req_err = 1'b0;
        case (bus.req_op)
            OP_SW:   req_err = (bus.req_addr[1:0] != 2'b00);
            OP_SH:   req_err = bus.req_addr[0];
            OP_SB:   req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
    end

    // Upper bits are dropped at the door so they can never leak into memory.
    always_comb begin
        req_trunc = bus.req_wdata;
        if (bus.req_op == OP_SB) begin
            req_trunc = {24'd0, bus.req_wdata[7:0]};
        end else if (bus.req_op == OP_SH) begin
            req_trunc = {16'd0, bus.req_wdata[15:0]};
        end
    end

    // Big-endian lane k sits (3-k) bytes up; halves at offset 0/2 sit 16/0 bits up.
    always_comb begin
        lane_sh   = 5'd0;
        lane_mask = 32'h0000_FFFF;
        if (op_q == OP_SB) begin
            lane_mask = 32'h0000_00FF;
            lane_sh   = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
        end else begin
            lane_sh   = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
        end
    end

    assign merged = (bus.mem_rdata & ~(lane_mask << lane_sh)) |
                    ((data_q << lane_sh) & (lane_mask << lane_sh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= 2'b00;
            addr_q   <= '0;
            data_q   <= 32'd0;
            merged_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= bus.req_op;
                        addr_q <= bus.req_addr;
                        data_q <= req_trunc;
                        if (req_err) begin
                            state <= S_ERR;
                        end else if (bus.req_op == OP_SW) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD:    state <= S_RWAIT;
                S_RWAIT: begin
                    merged_q <= merged;
                    state    <= S_WR;
                end
                S_WR:    state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating with rst_n keeps ready low for the whole reset, not only after the first edge.
    assign bus.req_ready  = rst_n & (state == S_IDLE);
    assign mem_en         = (state == S_RD) | (state == S_WR);
    assign mem_we         = (state == S_WR);
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_en ? addr_q[ADDR_W-1:2] : '0;
    assign bus.mem_wdata  = mem_we ? ((op_q == OP_SW) ? data_q : merged_q) : 32'd0;
    assign bus.resp_valid = (state == S_RESP) | (state == S_ERR);
    assign bus.resp_err   = (state == S_ERR);
endmodule

// File: tb/tb_store_merge.sv
// Drives one request stream into a big-endian and a little-endian store_merge, each with its own word RAM.
// A scoreboard of expected writes/responses is filled at drive time and drained by a negedge monitor.
module tb_store_merge;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    store_merge_if #(.ADDR_W(32)) be_if ();
    store_merge_if #(.ADDR_W(32)) le_if ();

    store_merge #(.BIG_ENDIAN(1'b1), .ADDR_W(32)) dut_be (.clk(clk), .rst_n(rst_n), .bus(be_if));
    store_merge #(.BIG_ENDIAN(1'b0), .ADDR_W(32)) dut_le (.clk(clk), .rst_n(rst_n), .bus(le_if));

    logic [31:0] rdq [2];

    assign be_if.req_valid = req_valid;
    assign be_if.req_op    = req_op;
    assign be_if.req_addr  = req_addr;
    assign be_if.req_wdata = req_wdata;
    assign be_if.mem_rdata = rdq[0];
    assign le_if.req_valid = req_valid;
    assign le_if.req_op    = req_op;
    assign le_if.req_addr  = req_addr;
    assign le_if.req_wdata = req_wdata;
    assign le_if.mem_rdata = rdq[1];

    logic [1:0]  s_rdy, s_rv, s_re, s_en, s_we;
    logic [29:0] s_addr [2];
    logic [31:0] s_wd   [2];

    assign s_rdy[0] = be_if.req_ready;   assign s_rdy[1] = le_if.req_ready;
    assign s_rv[0]  = be_if.resp_valid;  assign s_rv[1]  = le_if.resp_valid;
    assign s_re[0]  = be_if.resp_err;    assign s_re[1]  = le_if.resp_err;
    assign s_en[0]  = be_if.mem_en;      assign s_en[1]  = le_if.mem_en;
    assign s_we[0]  = be_if.mem_we;      assign s_we[1]  = le_if.mem_we;
    assign s_addr[0] = be_if.mem_addr;   assign s_addr[1] = le_if.mem_addr;
    assign s_wd[0]  = be_if.mem_wdata;   assign s_wd[1]  = le_if.mem_wdata;

    logic [31:0] ram    [2][256];
    logic [31:0] shadow [2][256];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rdq[d] = 32'd0;
            for (int i = 0; i < 256; i++) ram[d][i] = 32'h1122_3344;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (s_en[d]) begin
                    if (s_we[d]) ram[d][s_addr[d][7:0]] <= s_wd[d];
                    else         rdq[d] <= ram[d][s_addr[d][7:0]];
                end
            end
        end
    end

    typedef struct {
        bit          err;
        bit          rmw;
        logic [29:0] waddr;
        logic [31:0] wdata;
    } txn_t;

    txn_t txq  [2][$];
    int   accq [2][$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference placement written byte-by-byte in memory order, independent of any shift trick.
    function automatic logic [31:0] model_word(input bit be, input logic [1:0] op, input logic [1:0] off,
                                               input logic [31:0] wd, input logic [31:0] old);
        logic [31:0] w;
        int p;
        w = old;
        if (op == 2'b10) begin
            p = be ? (3 - int'(off)) : int'(off);
            w[8*p +: 8] = wd[7:0];
        end else if (op == 2'b01) begin
            p = be ? (3 - int'(off)) : int'(off);
            w[8*p +: 8] = be ? wd[15:8] : wd[7:0];
            p = be ? (2 - int'(off)) : (int'(off) + 1);
            w[8*p +: 8] = be ? wd[7:0] : wd[15:8];
        end else begin
            w = wd;
        end
        return w;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
        txn_t t;
        bit   e;
        int   budget;
        e = (op == 2'b11) || (op == 2'b01 && addr[0]) || (op == 2'b00 && addr[1:0] != 2'b00);
        for (int d = 0; d < 2; d++) begin
            t.err   = e;
            t.rmw   = (op != 2'b00);
            t.waddr = addr[31:2];
            t.wdata = 32'd0;
            if (!e) begin
                t.wdata = model_word(d == 0, op, addr[1:0], wd, shadow[d][addr[9:2]]);
                shadow[d][addr[9:2]] = t.wdata;
            end
            txq[d].push_back(t);
        end
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(s_rdy[0] && s_rdy[1]) && budget < 50);
        if (!(s_rdy[0] && s_rdy[1])) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic mon_step(input int d);
        txn_t  t;
        int    off;
        string pf;
        pf = (d == 0) ? "be_" : "le_";
        if (!s_we[d]) chk({pf, "wdata_idle"}, s_wd[d], 32'd0);
        if (req_valid && s_rdy[d]) accq[d].push_back(cyc);
        if (s_en[d] || s_rv[d]) begin
            if (txq[d].size() == 0 || accq[d].size() == 0) begin
                chk({pf, "unexpected_event"}, 32'd1, 32'd0);
            end else begin
                t   = txq[d][0];
                off = cyc - accq[d][0];
                if (s_en[d]) begin
                    chk({pf, "mem_on_err"}, 32'(t.err), 32'd0);
                    chk({pf, "mem_addr"}, 32'(s_addr[d]), 32'(t.waddr));
                    if (s_we[d]) begin
                        chk({pf, "wr_lat"}, off, t.rmw ? 32'd3 : 32'd1);
                        chk({pf, "wr_data"}, s_wd[d], t.wdata);
                    end else begin
                        chk({pf, "rd_lat"}, off, 32'd1);
                        chk({pf, "rd_is_rmw"}, 32'(t.rmw), 32'd1);
                    end
                end
                if (s_rv[d]) begin
                    chk({pf, "resp_err"}, 32'(s_re[d]), 32'(t.err));
                    chk({pf, "resp_lat"}, off, t.err ? 32'd1 : (t.rmw ? 32'd4 : 32'd2));
                    void'(txq[d].pop_front());
                    void'(accq[d].pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    task automatic chk_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_ready"}, 32'(s_rdy[d]), 32'd0);
            chk({tag, "_resp_valid"}, 32'(s_rv[d]), 32'd0);
            chk({tag, "_resp_err"}, 32'(s_re[d]), 32'd0);
            chk({tag, "_mem_en"}, 32'(s_en[d]), 32'd0);
            chk({tag, "_mem_we"}, 32'(s_we[d]), 32'd0);
            chk({tag, "_mem_addr"}, 32'(s_addr[d]), 32'd0);
            chk({tag, "_mem_wdata"}, s_wd[d], 32'd0);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((txq[0].size() != 0 || txq[1].size() != 0) && b < 60) begin
            @(posedge clk);
            b++;
        end
        chk("drain_timeout", 32'(txq[0].size() + txq[1].size()), 32'd0);
        #2;
    endtask

    initial begin
        mon_en = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_addr = 32'd0; req_wdata = 32'd0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) shadow[d][i] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_reset", 32'(s_rdy), 32'd3);
        @(posedge clk); #2;

        // Byte lanes at each offset, both halves, then an aligned word.
        issue(2'b10, 32'h101, 32'hFFFF_FFAB);
        issue(2'b10, 32'h104, 32'hFFFF_FFAB);
        issue(2'b10, 32'h10A, 32'hFFFF_FFAB);
        issue(2'b10, 32'h10F, 32'hFFFF_FFAB);
        issue(2'b01, 32'h112, 32'h0000_CAFE);
        issue(2'b01, 32'h114, 32'hBEEF_1234);
        issue(2'b00, 32'h100, 32'hDEAD_BEEF);
        issue(2'b01, 32'h103, 32'h0000_5555);
        issue(2'b00, 32'h102, 32'h1234_5678);
        issue(2'b11, 32'h100, 32'h8765_4321);
        drain();

        chk("be_sw_0x100",  ram[0][8'h40], 32'hDEAD_BEEF);
        chk("be_sb_off0",   ram[0][8'h41], 32'hAB22_3344);
        chk("be_sb_off2",   ram[0][8'h42], 32'h1122_AB44);
        chk("be_sb_off3",   ram[0][8'h43], 32'h1122_33AB);
        chk("be_sh_off2",   ram[0][8'h44], 32'h1122_CAFE);
        chk("le_sh_off2",   ram[1][8'h44], 32'hCAFE_3344);
        chk("be_sh_off0",   ram[0][8'h45], 32'h1234_3344);
        chk("le_sh_off0",   ram[1][8'h45], 32'h1122_1234);
        chk("le_sb_off3",   ram[1][8'h43], 32'hAB22_3344);

        // Reset lands in RWAIT of an SB: nothing may be written.
        mon_en = 1'b0;
        req_op = 2'b10; req_addr = 32'h121; req_wdata = 32'hFFFF_FF77; req_valid = 1'b1;
        @(negedge clk);
        chk("rmw_rst_accept", 32'(s_rdy), 32'd3);
        @(posedge clk); #2 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst_read_en", 32'(s_en), 32'd3);
        chk("rmw_rst_read_we", 32'(s_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rmw_reset");
        repeat (2) @(negedge clk);
        chk_quiet("held_reset");
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_rmw_reset", 32'(s_rdy), 32'd3);
        chk("be_ram_untouched", ram[0][8'h48], 32'h1122_3344);
        chk("le_ram_untouched", ram[1][8'h48], 32'h1122_3344);
        mon_en = 1'b1;
        @(posedge clk); #2;
        issue(2'b00, 32'h120, 32'hA5A5_A5A5);
        drain();
        chk("sw_after_reset", ram[0][8'h48], 32'hA5A5_A5A5);

        // Second request is presented while the first is busy and must wait.
        issue(2'b10, 32'h131, 32'h0000_0055);
        issue(2'b00, 32'h134, 32'h0102_0304);
        drain();

        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), 32'h140 + 32'($urandom_range(0, 63)), $urandom);
        end
        drain();

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                if (ram[d][i] !== shadow[d][i]) chk("final_ram", ram[d][i], shadow[d][i]);
            end
        end
        chk("acc_queue_empty", 32'(accq[0].size() + accq[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
